// File: rtl/alarm_clock_multi_if.sv
// ----------------------------------------------------------------------------
// alarm_clock_multi_if
//   Alarm-channel write bus for alarm_clock_multi. One write per clock:
//   wr_en qualifies wr_idx/wr_hr/wr_min/wr_arm in the same cycle.
//
//   Signals
//     wr_en    1      write strobe
//     wr_idx   IDX_W  channel select, IDX_W = max(1, $clog2(N_ALARMS))
//     wr_hr    8      BCD alarm hour   00..23
//     wr_min   8      BCD alarm minute 00..59
//     wr_arm   1      1 = arm, 0 = disarm
//
//   Modports
//     master   drives the bus (host / testbench)
//     slave    receives the bus (alarm_clock_multi)
// ----------------------------------------------------------------------------
interface alarm_clock_multi_if #(
    parameter int N_ALARMS = 4
);
    localparam int IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_hr;
    logic [7:0]       wr_min;
    logic             wr_arm;

    modport master (output wr_en, wr_idx, wr_hr, wr_min, wr_arm);
    modport slave  (input  wr_en, wr_idx, wr_hr, wr_min, wr_arm);
endinterface

// File: rtl/alarm_clock_multi.sv
// ----------------------------------------------------------------------------
// alarm_clock_multi
//   BCD 24-hour timekeeper (hh:mm:ss) advanced once per rising edge of the
//   1 Hz clock, with N_ALARMS independently armed alarm channels. Each channel
//   rings for RING_SECS seconds unless stopped; optionally it can be snoozed
//   for SNOOZE_MIN minutes.
//
//   Build option
//     ALARM_SNOOZE_EN  defined   : SNOOZED state, snooze counter, snooze_key
//                      undefined : snooze_key ignored, no SNOOZED state
//
//   Ports
//     _1Hz          in   1         clock, all state advances on rising edge
//     nCR           in   1         asynchronous active-low reset
//     AdjMinkey     in   1         minute +1 per clock (no hour carry)
//     AdjHrkey      in   1         hour +1 per clock, wins over AdjMinkey
//     wr            slave         alarm-channel write bus
//     stop_key      in   1         clear every RINGING/SNOOZED channel
//     snooze_key    in   1         move every RINGING channel to SNOOZED
//     Hour/Minute/Second out 8     BCD current time
//     ALARM_Clock   out  1         OR of all ringing channels
//     alarm_active  out  N_ALARMS  per-channel ringing flag
// ----------------------------------------------------------------------------
module alarm_clock_multi #(
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                _1Hz,
    input  logic                nCR,
    input  logic                AdjMinkey,
    input  logic                AdjHrkey,
    alarm_clock_multi_if.slave  wr,
    input  logic                stop_key,
    input  logic                snooze_key,
    output logic [7:0]          Hour,
    output logic [7:0]          Minute,
    output logic [7:0]          Second,
    output logic                ALARM_Clock,
    output logic [N_ALARMS-1:0] alarm_active
);

    localparam int         IDX_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam logic [7:0] MAX_HR      = 8'h23;
    localparam logic [7:0] MAX_MS      = 8'h59;
    // Counters load "duration - 1" and leave their state when they hit zero,
    // so a channel spends exactly the full duration in that state.
    localparam logic [7:0] RING_RELOAD = 8'(RING_SECS - 1);

`ifdef ALARM_SNOOZE_EN
    localparam logic [11:0] SNZ_RELOAD = 12'(SNOOZE_MIN * 60 - 1);
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
`else
    typedef enum logic {IDLE, RINGING} state_t;
    logic unused_snooze;
    assign unused_snooze = snooze_key;
`endif

    // BCD increment with wrap at 'top'; low nibble carries into high nibble.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)         return 8'h00;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    logic adj;
    assign adj = AdjHrkey | AdjMinkey;

    // ------------------------------------------------------------------
    // Timekeeping
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, like real hardware.
    always_ff @(posedge _1Hz or negedge nCR) begin
        if (!nCR) begin
            Hour   <= 8'h00;
            Minute <= 8'h00;
            Second <= 8'h00;
        end else if (AdjHrkey) begin
            Hour <= bcd_inc(Hour, MAX_HR);
        end else if (AdjMinkey) begin
            Minute <= bcd_inc(Minute, MAX_MS);
        end else begin
            Second <= bcd_inc(Second, MAX_MS);
            if (Second == MAX_MS) begin
                Minute <= bcd_inc(Minute, MAX_MS);
                if (Minute == MAX_MS) Hour <= bcd_inc(Hour, MAX_HR);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write qualification (shared by all channels)
    // ------------------------------------------------------------------
    logic hr_ok, min_ok, wr_ok;
    assign hr_ok  = (wr.wr_hr[3:0] <= 4'd9) &&
                    ((wr.wr_hr[7:4] <= 4'd1) ||
                     (wr.wr_hr[7:4] == 4'd2 && wr.wr_hr[3:0] <= 4'd3));
    assign min_ok = (wr.wr_min[3:0] <= 4'd9) && (wr.wr_min[7:4] <= 4'd5);
    assign wr_ok  = wr.wr_en && hr_ok && min_ok;

    // ------------------------------------------------------------------
    // Alarm channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
        logic [7:0] set_hr;
        logic [7:0] set_min;
        logic       armed;
        state_t     state;
        logic [7:0] ring_cnt;
        logic       ringing;
        logic       hit;
        logic       match;
`ifdef ALARM_SNOOZE_EN
        logic [11:0] snz_cnt;
`endif

        // An out-of-range wr_idx matches no channel, so such writes vanish.
        assign hit   = wr_ok && (wr.wr_idx == IDX_W'(i));
        // Seconds == 00 makes the match a single-cycle event per minute.
        // stop_key outranks a trigger landing on the same edge.
        assign match = armed && !adj && !stop_key && (Second == 8'h00) &&
                       (Hour == set_hr) && (Minute == set_min);

        // NOTE: the per-channel set/arm registers are reset along with the
        // FSM, because a channel must come up disarmed at 00:00.
        always_ff @(posedge _1Hz or negedge nCR) begin
            if (!nCR) begin
                set_hr   <= 8'h00;
                set_min  <= 8'h00;
                armed    <= 1'b0;
                state    <= IDLE;
                ring_cnt <= '0;
                ringing  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                snz_cnt  <= '0;
`endif
            end else if (hit) begin
                set_hr  <= wr.wr_hr;
                set_min <= wr.wr_min;
                armed   <= wr.wr_arm;
                state   <= IDLE;
                ringing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (match) begin
                            state    <= RINGING;
                            ring_cnt <= RING_RELOAD;
                            ringing  <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (stop_key) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                        end
`ifdef ALARM_SNOOZE_EN
                        else if (snooze_key) begin
                            state   <= SNOOZED;
                            snz_cnt <= SNZ_RELOAD;
                            ringing <= 1'b0;
                        end
`endif
                        else if (ring_cnt == 8'd0) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt - 8'd1;
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    SNOOZED: begin
                        if (stop_key) begin
                            state <= IDLE;
                        end else if (!adj) begin
                            // Re-ring is time-based only; the set time is not rechecked.
                            if (snz_cnt == 12'd0) begin
                                state    <= RINGING;
                                ring_cnt <= RING_RELOAD;
                                ringing  <= 1'b1;
                            end else begin
                                snz_cnt <= snz_cnt - 12'd1;
                            end
                        end
                    end
`endif
                    default: begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                    end
                endcase
            end
        end

        assign alarm_active[i] = ringing;
    end

    assign ALARM_Clock = |alarm_active;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// ----------------------------------------------------------------------------
// tb_alarm_clock_multi
//   Self-checking bench for alarm_clock_multi. The reference model keeps the
//   time as seconds-of-day and each channel as set hour/minute (integers), an
//   arm bit, a state code and "seconds left" counters. Three channels are used
//   so that wr_idx = 3 is an out-of-range channel on a 2-bit index.
// ----------------------------------------------------------------------------
module tb_alarm_clock_multi;

    localparam int N       = 3;
    localparam int RING    = 60;
    localparam int SNZ_MIN = 5;
    localparam int W       = 24 + N + 1;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif
    localparam int ST_IDLE = 0, ST_RING = 1, ST_SNZ = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic adj_min = 1'b0, adj_hr = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic [7:0]   hour, minute, second;
    logic         alarm_clock;
    logic [N-1:0] active;
    logic [W-1:0] obs;

    alarm_clock_multi_if #(.N_ALARMS(N)) bif ();

    alarm_clock_multi #(.N_ALARMS(N), .RING_SECS(RING), .SNOOZE_MIN(SNZ_MIN)) dut (
        ._1Hz(clk), .nCR(rst_n), .AdjMinkey(adj_min), .AdjHrkey(adj_hr), .wr(bif),
        .stop_key(stop), .snooze_key(snooze), .Hour(hour), .Minute(minute),
        .Second(second), .ALARM_Clock(alarm_clock), .alarm_active(active)
    );

    always #5 clk = ~clk;
    assign obs = {hour, minute, second, active, alarm_clock};

    int errors = 0, checks = 0;

    // ---------------- reference model ----------------
    int t;
    int set_h[N], set_m[N], st[N], ring_left[N], snz_left[N];
    bit armed[N];

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [W-1:0] exp_vec();
        logic [N-1:0] a;
        a = '0;
        for (int c = 0; c < N; c++) a[c] = (st[c] == ST_RING);
        return {bcd(t / 3600), bcd((t / 60) % 60), bcd(t % 60), a, |a};
    endfunction

    task automatic model_reset();
        t = 0;
        for (int c = 0; c < N; c++) begin
            set_h[c] = 0; set_m[c] = 0; armed[c] = 0;
            st[c] = ST_IDLE; ring_left[c] = 0; snz_left[c] = 0;
        end
    endtask

    task automatic model_step();
        int h, m, s, hh, hl, mh, ml;
        bit adj, wr_ok;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        adj = adj_hr || adj_min;
        hh = int'(bif.wr_hr) / 16;  hl = int'(bif.wr_hr) % 16;
        mh = int'(bif.wr_min) / 16; ml = int'(bif.wr_min) % 16;
        wr_ok = bif.wr_en && hh <= 9 && hl <= 9 && mh <= 9 && ml <= 9 &&
                (hh * 10 + hl) <= 23 && (mh * 10 + ml) <= 59 && int'(bif.wr_idx) < N;
        for (int c = 0; c < N; c++) begin
            if (wr_ok && int'(bif.wr_idx) == c) begin
                set_h[c] = hh * 10 + hl; set_m[c] = mh * 10 + ml;
                armed[c] = bif.wr_arm; st[c] = ST_IDLE;
            end else if (stop) begin
                st[c] = ST_IDLE;
            end else if (SNZ_EN && snooze && st[c] == ST_RING) begin
                st[c] = ST_SNZ; snz_left[c] = SNZ_MIN * 60;
            end else if (st[c] == ST_RING) begin
                ring_left[c]--;
                if (ring_left[c] == 0) st[c] = ST_IDLE;
            end else if (st[c] == ST_SNZ) begin
                if (!adj) begin
                    snz_left[c]--;
                    if (snz_left[c] == 0) begin st[c] = ST_RING; ring_left[c] = RING; end
                end
            end else if (armed[c] && !adj && h == set_h[c] && m == set_m[c] && s == 0) begin
                st[c] = ST_RING; ring_left[c] = RING;
            end
        end
        if (adj_hr)       t = ((h + 1) % 24) * 3600 + m * 60 + s;
        else if (adj_min) t = h * 3600 + ((m + 1) % 60) * 60 + s;
        else              t = (t + 1) % 86400;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic goto_hm(input int h, input int m);
        do_reset();
        adj_hr = 1'b1;  run(h); adj_hr = 1'b0;
        adj_min = 1'b1; run(m); adj_min = 1'b0;
    endtask

    task automatic write_ch(input int idx, input logic [7:0] hr, input logic [7:0] mn, input logic arm);
        bif.wr_en = 1'b1; bif.wr_idx = 2'(idx); bif.wr_hr = hr; bif.wr_min = mn; bif.wr_arm = arm;
        step();
        bif.wr_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_first_tick: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_timekeeping();
        do_reset();
        run(3600);
        checks++;
        if ({hour, minute, second} !== 24'h010000) begin
            errors++; $display("FAIL one_hour: got %h want 010000", {hour, minute, second});
        end
        adj_hr = 1'b1; run(22); adj_hr = 1'b0;
        adj_min = 1'b1; run(59); adj_min = 1'b0;
        checks++;
        if ({hour, minute, second} !== 24'h235900) begin
            errors++; $display("FAIL adjust_to_2359: got %h want 235900", {hour, minute, second});
        end
        adj_min = 1'b1; step(); adj_min = 1'b0;
        checks++;
        if ({hour, minute, second} !== 24'h230000) begin
            errors++; $display("FAIL adjmin_no_carry: got %h want 230000", {hour, minute, second});
        end
        adj_min = 1'b1; run(59); adj_min = 1'b0;
        run(59);
        checks++;
        if ({hour, minute, second} !== 24'h235959) begin
            errors++; $display("FAIL reach_235959: got %h want 235959", {hour, minute, second});
        end
        step();
        checks++;
        if ({hour, minute, second} !== 24'h000000) begin
            errors++; $display("FAIL midnight_wrap: got %h want 000000", {hour, minute, second});
        end
        adj_hr = 1'b1; adj_min = 1'b1; step(); adj_hr = 1'b0; adj_min = 1'b0;
        checks++;
        if (obs !== exp_vec() || {hour, minute, second} !== 24'h010000) begin
            errors++; $display("FAIL adjhr_priority: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_single_alarm();
        logic [15:0] rise_at;
        int high_cycles;
        logic prev;
        rise_at = 16'hFFFF; high_cycles = 0; prev = 1'b0;
        goto_hm(7, 29);
        write_ch(0, 8'h07, 8'h30, 1'b1);
        for (int i = 0; i < 200; i++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL single_alarm_cycle%0d: got %h want %h", i, obs, exp_vec()); end
            if (active[0] && !prev && rise_at == 16'hFFFF) rise_at = {minute, second};
            if (active[0]) high_cycles++;
            prev = active[0];
        end
        checks++;
        if (rise_at !== 16'h3001) begin errors++; $display("FAIL single_alarm_rise: got %h want 3001", rise_at); end
        checks++;
        if (high_cycles != RING) begin errors++; $display("FAIL single_alarm_ring_len: got %0d want %0d", high_cycles, RING); end
    endtask

    task automatic test_snooze();
        logic [15:0] rerise_at;
        logic prev;
        rerise_at = 16'hFFFF;
        goto_hm(7, 59);
        write_ch(1, 8'h08, 8'h00, 1'b1);
        run(64);
        checks++;
        if (active !== 3'b010 || {minute, second} !== 16'h0005) begin
            errors++; $display("FAIL snooze_ringing: got act=%b t=%h want act=010 t=0005", active, {minute, second});
        end
        snooze = 1'b1; step(); snooze = 1'b0;
        checks++;
        if (alarm_clock !== !SNZ_EN) begin errors++; $display("FAIL snooze_silences: got %b want %b", alarm_clock, !SNZ_EN); end
        prev = active[1];
        for (int i = 0; i < 310; i++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL snooze_cycle%0d: got %h want %h", i, obs, exp_vec()); end
            if (active[1] && !prev && rerise_at == 16'hFFFF) rerise_at = {minute, second};
            prev = active[1];
        end
        checks++;
        if (rerise_at !== (SNZ_EN ? 16'h0506 : 16'hFFFF)) begin
            errors++; $display("FAIL snooze_rering: got %h want %h", rerise_at, SNZ_EN ? 16'h0506 : 16'hFFFF);
        end
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (active !== '0 || obs !== exp_vec()) begin errors++; $display("FAIL snooze_stop: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_same_time();
        goto_hm(11, 59);
        write_ch(0, 8'h12, 8'h00, 1'b1);
        write_ch(2, 8'h12, 8'h00, 1'b1);
        run(59);
        checks++;
        if (active !== 3'b101 || alarm_clock !== 1'b1) begin
            errors++; $display("FAIL same_time_both: got act=%b any=%b want 101/1", active, alarm_clock);
        end
        stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
        checks++;
        if (active !== 3'b000 || alarm_clock !== 1'b0) begin
            errors++; $display("FAIL stop_and_snooze: got act=%b any=%b want 000/0", active, alarm_clock);
        end
    endtask

    task automatic test_writes();
        goto_hm(9, 59);
        write_ch(0, 8'h10, 8'h00, 1'b1);
        write_ch(1, 8'h10, 8'h00, 1'b1);
        write_ch(0, 8'h24, 8'h00, 1'b0);
        write_ch(1, 8'h10, 8'h5A, 1'b0);
        write_ch(0, 8'h1A, 8'h00, 1'b0);
        write_ch(1, 8'h10, 8'hA0, 1'b0);
        write_ch(3, 8'h10, 8'h00, 1'b0);
        run(54);
        checks++;
        if (active !== 3'b011 || obs !== exp_vec()) begin
            errors++; $display("FAIL invalid_writes_ignored: got %h want %h", obs, exp_vec());
        end
        write_ch(0, 8'h10, 8'h00, 1'b1);
        checks++;
        if (active !== 3'b010) begin errors++; $display("FAIL write_forces_idle: got %b want 010", active); end
        stop = 1'b1; step(); stop = 1'b0;
        do_reset();
        adj_hr = 1'b1;
        write_ch(2, 8'h10, 8'h05, 1'b1);
        run(9);
        adj_hr = 1'b0; adj_min = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (active !== '0 || obs !== exp_vec()) begin errors++; $display("FAIL adjmin_no_trigger%0d: got %h want %h", i, obs, exp_vec()); end
        end
        adj_min = 1'b0;
        run(5);
        checks++;
        if (obs !== exp_vec() || {hour, minute, active} !== {16'h1010, 3'b000}) begin
            errors++; $display("FAIL after_adjust: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        int h, m;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            h = t / 3600; m = (t / 60) % 60;
            bif.wr_en = ($urandom_range(0, 99) < 4);
            bif.wr_idx = 2'($urandom_range(0, 3));
            bif.wr_arm = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bif.wr_hr = 8'($urandom); bif.wr_min = 8'($urandom);
            end else begin
                bif.wr_hr = bcd(h); bif.wr_min = bcd((m + $urandom_range(0, 2)) % 60);
            end
            adj_min = ($urandom_range(0, 99) < 2);
            adj_hr  = ($urandom_range(0, 199) == 0);
            stop    = ($urandom_range(0, 99) == 0);
            snooze  = ($urandom_range(0, 99) < 3);
            step();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_vec()); end
        end
        bif.wr_en = 1'b0; adj_min = 1'b0; adj_hr = 1'b0; stop = 1'b0; snooze = 1'b0;
    endtask

    task automatic test_reset_mid_ring();
        goto_hm(6, 59);
        write_ch(0, 8'h07, 8'h00, 1'b1);
        run(60);
        checks++;
        if (active !== 3'b001) begin errors++; $display("FAIL pre_reset_ringing: got %b want 001", active); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL after_reset_tick: got %h want %h", obs, exp_vec()); end
    endtask

    initial begin
        bif.wr_en = 1'b0; bif.wr_idx = '0; bif.wr_hr = '0; bif.wr_min = '0; bif.wr_arm = 1'b0;
        model_reset();
        test_reset();
        test_timekeeping();
        test_single_alarm();
        test_snooze();
        test_same_time();
        test_writes();
        test_random();
        test_reset_mid_ring();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
